// File: rtl/pipelined_addsub_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_addsub_unit_pkg
//  Purpose  : Shared definitions for the pipelined add/subtract datapath:
//             operation encodings, default geometry and the stage-count helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipelined_addsub_unit_pkg;

  // Operation select as seen on in_sub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default geometry: 32-bit operands, 8-bit blocks per stage.
  localparam int DEF_N = 32;
  localparam int DEF_K = 8;

  // Bits per lookahead group inside a block adder.
  localparam int CLA_GROUP = 4;

  // Number of blocks needed to cover num bits with den-bit blocks.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_unit_stage.sv
`default_nettype none
// ============================================================================
//  Module   : hierarchical_cla / addsub_stage
//  Purpose  : One W-bit block of the pipelined adder. hierarchical_cla is a
//             two-level carry-lookahead adder (4-bit groups, lookahead across
//             groups). addsub_stage evaluates the block for both possible
//             carry-ins and selects with the carry registered upstream.
//  Ports (hierarchical_cla):
//    a, b     in  W  block operands
//    cin      in  1  carry in
//    sum      out W  block sum
//    cout     out 1  carry out of the block
//    c_msb    out 1  carry into the block MSB
//  Ports (addsub_stage):
//    a_blk, b_blk in  W  block operands (b already conditioned for sub)
//    sel_cin      in  1  carry arriving from the previous stage
//    s_blk        out W  selected block sum
//    cout         out 1  selected carry out
//    c_msb        out 1  selected carry into the block MSB
//  Revision : 1.0  initial release
// ============================================================================
module hierarchical_cla
  import pipelined_addsub_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  localparam int NG = ceil_div(W, CLA_GROUP);

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG-1:0] cg;
  logic [W:0]    c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '1;
    cg = '0;
    c  = '0;
    cg[0] = cin;
    // Level 1: group generate/propagate; level 2: group carries by lookahead.
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < CLA_GROUP; k++) begin
        if (j * CLA_GROUP + k < W) begin
          gg[j] = g[j*CLA_GROUP+k] | (p[j*CLA_GROUP+k] & gg[j]);
          gp[j] = gp[j] & p[j*CLA_GROUP+k];
        end
      end
      if (j < NG - 1) begin
        cg[j+1] = gg[j] | (gp[j] & cg[j]);
      end
    end
    // Bit carries inside each group start from that group's lookahead carry.
    for (int k = 0; k < W; k++) begin
      if (k % CLA_GROUP == 0) begin
        c[k] = cg[k/CLA_GROUP];
      end
      c[k+1] = g[k] | (p[k] & c[k]);
    end
  end

  assign sum   = p ^ c[W-1:0];
  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

module addsub_stage #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_blk,
  input  logic [W-1:0] b_blk,
  input  logic         sel_cin,
  output logic [W-1:0] s_blk,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic         co0;
  logic         co1;
  logic         m0;
  logic         m1;

  hierarchical_cla #(.W(W)) u_cla_c0 (
    .a     (a_blk),
    .b     (b_blk),
    .cin   (1'b0),
    .sum   (s0),
    .cout  (co0),
    .c_msb (m0)
  );

  hierarchical_cla #(.W(W)) u_cla_c1 (
    .a     (a_blk),
    .b     (b_blk),
    .cin   (1'b1),
    .sum   (s1),
    .cout  (co1),
    .c_msb (m1)
  );

  // Carry-select: the only path from sel_cin is this mux.
  assign s_blk = sel_cin ? s1  : s0;
  assign cout  = sel_cin ? co1 : co0;
  assign c_msb = sel_cin ? m1  : m0;

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_addsub_unit
//  Purpose  : Pipelined N-bit two's-complement adder/subtractor, one K-bit
//             block per stage (NB = ceil(N/K) stages, last block may be
//             narrower). Carry is registered between stages; unprocessed
//             operand bits travel with the beat and finished result bits are
//             held until the whole word leaves together. valid/ready on both
//             sides with a global stall.
//  Ports:
//    CLOCK_50   in  1  clock, rising edge
//    RESET_N    in  1  asynchronous active-low reset
//    in_valid   in  1  operand beat offered
//    in_ready   out 1  beat accepted this cycle when in_valid is high
//    in_sub     in  1  1: A-B, 0: A+B
//    in_a/in_b  in  N  operands
//    out_valid  out 1  result beat present
//    out_ready  in  1  consumer takes the result
//    out_s      out N  result
//    out_c      out 1  add: carry out, sub: borrow (A<B unsigned)
//    out_z      out 1  result is zero
//    out_n      out 1  result MSB
//    out_v      out 1  signed overflow
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_addsub_unit
  import pipelined_addsub_unit_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_c,
  output logic         out_z,
  output logic         out_n,
  output logic         out_v
);

  localparam int NB   = ceil_div(N, K);
  localparam int LAST = N - (NB - 1) * K;
  localparam int NF   = (NB > 1) ? NB - 1 : 1;

  logic         advance;
  logic [N-1:0] b_eff;

  // Registered state of every stage except the last, indexed by stage.
  logic         stg_valid [NF];
  logic         stg_carry [NF];
  logic         stg_sub   [NF];
  logic [N-1:0] stg_a     [NF];
  logic [N-1:0] stg_b     [NF];
  logic [N-1:0] stg_s     [NF];

  // Global stall: every stage, bubbles included, moves only when the
  // output slot is empty or being drained. Independent of in_valid.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Subtraction as A + ~B + 1; the +1 is the carry into block 0.
  assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;

  for (genvar gi = 0; gi < NB; gi++) begin : g_stage
    localparam int W = (gi == NB - 1) ? LAST : K;

    logic [N-1:0] a_src;
    logic [N-1:0] b_src;
    logic [N-1:0] s_src;
    logic         cin_src;
    logic         sub_src;
    logic         vld_src;
    logic [W-1:0] s_blk;
    logic         cout;
    logic         c_msb;
    logic [N-1:0] s_d;

    if (gi == 0) begin : g_head
      assign a_src   = in_a;
      assign b_src   = b_eff;
      assign s_src   = '0;
      assign cin_src = (in_sub == OP_SUB);
      assign sub_src = in_sub;
      assign vld_src = in_valid;
    end else begin : g_body
      assign a_src   = stg_a[gi-1];
      assign b_src   = stg_b[gi-1];
      assign s_src   = stg_s[gi-1];
      assign cin_src = stg_carry[gi-1];
      assign sub_src = stg_sub[gi-1];
      assign vld_src = stg_valid[gi-1];
    end

    // Operands are shifted down one block per stage, so the current block
    // always sits in the low bits.
    addsub_stage #(.W(W)) u_stage (
      .a_blk   (a_src[W-1:0]),
      .b_blk   (b_src[W-1:0]),
      .sel_cin (cin_src),
      .s_blk   (s_blk),
      .cout    (cout),
      .c_msb   (c_msb)
    );

    // Result bits above this block are still zero, so OR-in is a deposit.
    assign s_d = s_src | (N'(s_blk) << (gi * K));

    if (gi < NB - 1) begin : g_mid
      logic         valid_q;
      logic         carry_q;
      logic         sub_q;
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;
      logic [N-1:0] s_q;

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          sub_q   <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          s_q     <= '0;
        end else if (advance) begin
          valid_q <= vld_src;
          carry_q <= cout;
          sub_q   <= sub_src;
          a_q     <= a_src >> K;
          b_q     <= b_src >> K;
          s_q     <= s_d;
        end
      end

      assign stg_valid[gi] = valid_q;
      assign stg_carry[gi] = carry_q;
      assign stg_sub[gi]   = sub_q;
      assign stg_a[gi]     = a_q;
      assign stg_b[gi]     = b_q;
      assign stg_s[gi]     = s_q;
    end else begin : g_tail
      logic         valid_q;
      logic [N-1:0] s_q;
      logic         c_q;
      logic         z_q;
      logic         n_q;
      logic         v_q;
      logic         c_d;
      logic         v_d;

      // Carry out of the top block doubles as carry out of the MSB, and the
      // ragged last block reports its own carry into the MSB.
      assign c_d = (sub_src == OP_SUB) ? ~cout : cout;
      assign v_d = c_msb ^ cout;

      // Flags are registered so they read zero under reset along with out_s.
      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          valid_q <= 1'b0;
          s_q     <= '0;
          c_q     <= 1'b0;
          z_q     <= 1'b0;
          n_q     <= 1'b0;
          v_q     <= 1'b0;
        end else if (advance) begin
          valid_q <= vld_src;
          s_q     <= s_d;
          c_q     <= c_d;
          z_q     <= ~|s_d;
          n_q     <= s_d[N-1];
          v_q     <= v_d;
        end
      end

      assign out_valid = valid_q;
      assign out_s     = s_q;
      assign out_c     = c_q;
      assign out_z     = z_q;
      assign out_n     = n_q;
      assign out_v     = v_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_addsub_unit
//  Purpose  : Self-checking bench for pipelined_addsub_unit. A 32-bit/8-bit
//             instance is exercised with directed vectors, a stalled burst,
//             a mid-flight reset and a long random stream against an
//             arithmetic reference model; a 30-bit instance covers the
//             ragged last block.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_addsub_unit;

  localparam int N  = 32;
  localparam int NR = 30;
  localparam int K  = 8;
  localparam int NB = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [N-1:0]  in_a, in_b, out_s;
  logic          out_c, out_z, out_n, out_v;

  logic          r_in_valid, r_in_ready, r_in_sub, r_out_valid, r_out_ready;
  logic [NR-1:0] r_in_a, r_in_b, r_out_s;
  logic          r_out_c, r_out_z, r_out_n, r_out_v;

  pipelined_addsub_unit #(.N(N), .K(K)) dut (
    .CLOCK_50 (clk),       .RESET_N  (rst_n),
    .in_valid (in_valid),  .in_ready (in_ready),
    .in_sub   (in_sub),    .in_a     (in_a),     .in_b (in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s    (out_s),     .out_c    (out_c),    .out_z(out_z),
    .out_n    (out_n),     .out_v    (out_v)
  );

  pipelined_addsub_unit #(.N(NR), .K(K)) dut_rag (
    .CLOCK_50 (clk),         .RESET_N  (rst_n),
    .in_valid (r_in_valid),  .in_ready (r_in_ready),
    .in_sub   (r_in_sub),    .in_a     (r_in_a),    .in_b (r_in_b),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_s    (r_out_s),     .out_c    (r_out_c),   .out_z(r_out_z),
    .out_n    (r_out_n),     .out_v    (r_out_v)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [31:0] s, input logic c, input logic z,
                              input logic n, input logic v);
    res_t r;
    r.s = s; r.c = c; r.z = z; r.n = n; r.v = v;
    return r;
  endfunction

  // Reference: exact unsigned and signed integer arithmetic, then wrap.
  function automatic res_t ref_model(input int n, input logic sub,
                                     input logic [31:0] a, input logic [31:0] b);
    res_t            r;
    longint unsigned mask, ua, ub, full;
    longint          sa, sb, exact, half;
    mask  = (64'd1 << n) - 64'd1;
    ua    = {32'd0, a} & mask;
    ub    = {32'd0, b} & mask;
    half  = longint'(64'd1 << (n - 1));
    sa    = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb    = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
    full  = sub ? (ua - ub) : (ua + ub);
    exact = sub ? (sa - sb) : (sa + sb);
    r.s   = 32'(full & mask);
    r.c   = sub ? (ua < ub) : (((full >> n) & 64'd1) != 64'd0);
    r.z   = (r.s == 32'd0);
    r.n   = r.s[n-1];
    r.v   = (exact >= half) || (exact < -half);
    return r;
  endfunction

  function automatic logic [31:0] pick_operand(input int n);
    logic [31:0] v;
    int          sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = '1;
      3:       v = 32'd1 << (n - 1);
      4:       v = (32'd1 << (n - 1)) - 32'd1;
      default: v = $urandom;
    endcase
    if (n < 32) v = v & ((32'd1 << n) - 32'd1);
    return v;
  endfunction

  function automatic res_t main_res();
    return mk(out_s, out_c, out_z, out_n, out_v);
  endfunction

  function automatic res_t rag_res();
    return mk({2'b00, r_out_s}, r_out_c, r_out_z, r_out_n, r_out_v);
  endfunction

  // One beat into an empty pipe: check acceptance, latency and result.
  task automatic run_single(input bit rag, input logic sub, input logic [31:0] a,
                            input logic [31:0] b, input res_t exp, input string tag);
    int   lat;
    logic ov;
    @(negedge clk);
    if (rag) begin
      r_in_valid = 1'b1; r_in_sub = sub; r_in_a = a[NR-1:0]; r_in_b = b[NR-1:0];
      r_out_ready = 1'b1;
    end else begin
      in_valid = 1'b1; in_sub = sub; in_a = a; in_b = b;
      out_ready = 1'b1;
    end
    #1;
    check({tag, "_in_ready"}, 64'(rag ? r_in_ready : in_ready), 64'd1);
    @(negedge clk);
    r_in_valid = 1'b0;
    in_valid   = 1'b0;
    lat = 1;
    ov  = rag ? r_out_valid : out_valid;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
      ov = rag ? r_out_valid : out_valid;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NB));
    check({tag, "_result"}, 64'(rag ? rag_res() : main_res()), 64'(exp));
  endtask

  // Streamed beats through the scoreboard. stall_mode: continuous offers
  // with out_ready low for three cycles mid-stream; otherwise random.
  task automatic run_stream(input int nbeats, input bit stall_mode, input string tag);
    int   sent, got, cyc;
    bit   held;
    res_t h_res, e;
    sent = 0; got = 0; cyc = 0; held = 1'b0; h_res = '0;
    exp_q.delete();
    while ((sent < nbeats || exp_q.size() != 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(main_res()), 64'(h_res));
      end
      if (sent < nbeats && (stall_mode || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_sub   = 1'($urandom_range(0, 1));
        in_a     = pick_operand(N);
        in_b     = pick_operand(N);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = stall_mode ? !(cyc >= 6 && cyc <= 8) : ($urandom_range(0, 9) < 7);
      #1;
      if (stall_mode && out_valid && !out_ready)
        check({tag, "_in_ready_drop"}, 64'(in_ready), 64'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(N, in_sub, in_a, in_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "_result"}, 64'(main_res()), 64'(e));
        end
      end
      held = out_valid && !out_ready;
      if (held) h_res = main_res();
    end
    in_valid = 1'b0;
    check({tag, "_sent"}, 64'(sent), 64'(nbeats));
    check({tag, "_retired"}, 64'(got), 64'(sent));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        sub;
    int          w;
    in_valid = 0; in_sub = 0; in_a = '0; in_b = '0; out_ready = 1;
    r_in_valid = 0; r_in_sub = 0; r_in_a = '0; r_in_b = '0; r_out_ready = 1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_s", 64'(out_s), 64'd0);
    check("rst_flags", 64'({out_c, out_z, out_n, out_v}), 64'd0);
    check("rst_rag_out_valid", 64'(r_out_valid), 64'd0);
    rst_n = 1'b1;

    // Directed corner vectors.
    run_single(0, 1'b1, 32'd5,          32'd3, mk(32'd2,          0, 0, 0, 0), "sub_5_3");
    run_single(0, 1'b1, 32'd0,          32'd1, mk(32'hFFFF_FFFF,  1, 0, 1, 0), "sub_0_1");
    run_single(0, 1'b1, 32'h8000_0000,  32'd1, mk(32'h7FFF_FFFF,  0, 0, 0, 1), "sub_min_1");
    run_single(0, 1'b0, 32'hFFFF_FFFF,  32'd1, mk(32'd0,          1, 1, 0, 0), "add_max_1");
    run_single(0, 1'b0, 32'h7FFF_FFFF,  32'd1, mk(32'h8000_0000,  0, 0, 1, 1), "add_pos_1");

    // Back-to-back burst with a mid-stream stall.
    run_stream(8, 1'b1, "burst");

    // Reset with three beats in flight, output stalled so a result is visible.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sub = 1'b0; in_a = 32'(100 + i); in_b = 32'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rrst_setup_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rrst_async_valid", 64'(out_valid), 64'd0);
    check("rrst_async_s", 64'(out_s), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rrst_hold_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rrst_no_stale", 64'(out_valid), 64'd0);
    end
    run_single(0, 1'b1, 32'd9, 32'd4, mk(32'd5, 0, 0, 0, 0), "post_rst");

    // Ragged last block (N=30).
    run_single(1, 1'b1, 32'd0,         32'd1, mk(32'h3FFF_FFFF, 1, 0, 1, 0), "rag_sub_0_1");
    run_single(1, 1'b0, 32'h3FFF_FFFF, 32'd1, mk(32'd0,         1, 1, 0, 0), "rag_add_max");
    run_single(1, 1'b1, 32'h2000_0000, 32'd1, mk(32'h1FFF_FFFF, 0, 0, 0, 1), "rag_sub_ovf");
    for (int i = 0; i < 20; i++) begin
      sub = 1'($urandom_range(0, 1));
      a   = pick_operand(NR);
      b   = pick_operand(NR);
      run_single(1, sub, a, b, ref_model(NR, sub, a, b), "rag_rand");
    end

    // Long random stream with random backpressure.
    run_stream(10000, 1'b0, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
